// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: launches one req/ack transaction per load/store,
// stalls the pipeline until completion and flags misaligned/illegal/timed-out accesses.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [31:0]      addr_in,
  input  logic [31:0]      wdata_in,
  input  logic             dmem_ack,
  input  logic [31:0]      dmem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  output logic             stall,
  output logic [31:0]      load_data,
  output logic             load_valid,
  output logic             kill_wb,
  output logic             err_align,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              to_q, to_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       ldata_q, ldata_d;
  logic [CNT_W-1:0]  scnt_q;

  logic acc, both, mis;

  assign acc  = mem_read ^ mem_write;
  assign both = mem_read & mem_write;
  assign mis  = (addr_in[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    to_d        = to_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ldata_d     = ldata_q;
    stall       = 1'b0;
    load_valid  = 1'b0;
    kill_wb     = 1'b0;
    err_align   = 1'b0;
    err_illegal = 1'b0;
    err_timeout = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (both) begin
          err_illegal = 1'b1;
          kill_wb     = 1'b1;
        end else if (acc && mis) begin
          err_align = 1'b1;
          kill_wb   = 1'b1;
        end else if (acc) begin
          stall   = 1'b1;
          addr_d  = addr_in;
          wdata_d = wdata_in;
          we_d    = mem_write;
          req_d   = 1'b1;
          cnt_d   = '0;
          to_d    = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (dmem_ack) begin
          req_d = 1'b0;
          if (!we_q) ldata_d = dmem_rdata;
          state_d = S_DONE;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          // Abort: zero load_data so a stale value can never be mistaken for this load.
          req_d   = 1'b0;
          ldata_d = '0;
          to_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_DONE: begin
        if (to_q) begin
          err_timeout = 1'b1;
          kill_wb     = 1'b1;
        end else if (!we_q) begin
          load_valid = 1'b1;
        end
        to_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      to_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      to_q    <= to_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      if (stall && (scnt_q != {CNT_W{1'b1}})) scnt_q <= scnt_q + CNT_W'(1);
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign load_data    = ldata_q;
  assign busy         = (state_q != S_IDLE);
  assign stall_cycles = scnt_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage sequencer for the pipelined CPU. Sits between the EX/MEM pipeline register outputs and a variable-latency data memory with a req/ack handshake.
- Launches one memory transaction per load/store instruction and holds the pipeline with `stall` until the memory acknowledges.
- Returns load data to the MEM/WB path.
- Flags misaligned, illegal and timed-out accesses, and suppresses writeback for them.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles without ack before abort (must be >= 1).
- CNT_W, 32: width of the saturating stall-cycle performance counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- mem_read  input  1  MemRead from the EX/MEM register.
- mem_write  input  1  MemWrite from the EX/MEM register.
- addr_in  input  32  ALU result (byte address).
- wdata_in  input  32  store data (rd2).
- dmem_ack  input  1  memory completion, sampled only in WAIT.
- dmem_rdata  input  32  memory read data, valid with dmem_ack.
- dmem_req  output  1  transaction request; registered.
- dmem_we  output  1  1 = write, 0 = read; registered.
- dmem_addr  output  32  registered address.
- dmem_wdata  output  32  registered write data.
- stall  output  1  hold PC, IF/ID, ID/EX and EX/MEM; combinational from state/inputs.
- load_data  output  32  captured read data.
- load_valid  output  1  load_data valid this cycle.
- kill_wb  output  1  force RegWrite = 0 into MEM/WB this cycle.
- err_align  output  1  one-cycle misaligned-access flag.
- err_illegal  output  1  one-cycle flag when mem_read and mem_write are both set.
- err_timeout  output  1  one-cycle timeout flag.
- busy  output  1  state != IDLE.
- stall_cycles  output  CNT_W  count of cycles with stall = 1; saturates at all-ones.

Behaviour:
- States: IDLE, WAIT, DONE.
- `acc = mem_read ^ mem_write`; `both = mem_read & mem_write`; `mis = (addr_in[1:0] != 0)`.

Reset:
- State goes to IDLE.
- dmem_req, dmem_we, load_valid, err_* and the wait counter go to 0.
- dmem_addr, dmem_wdata, load_data and stall_cycles go to 0.
- Reset mid-WAIT drops dmem_req at that same edge. A late dmem_ack afterwards is ignored.

IDLE:
- If both: err_illegal = 1 and kill_wb = 1 this cycle; no request, no stall, stay IDLE.
- Else if acc & mis: err_align = 1 and kill_wb = 1 this cycle; no request, no stall, stay IDLE.
- Else if acc:
  - stall = 1 combinationally.
  - At the edge: dmem_addr <= addr_in, dmem_wdata <= wdata_in, dmem_we <= mem_write, dmem_req <= 1, counter <= 0; go to WAIT.
- Else: idle; all flags 0.

WAIT:
- stall = 1; dmem_req, dmem_we, dmem_addr and dmem_wdata held stable.
- dmem_ack = 1:
  - dmem_req <= 0.
  - If a read, load_data <= dmem_rdata.
  - Go to DONE.
- No ack and counter == TIMEOUT-1:
  - dmem_req <= 0, load_data <= 0.
  - Set the pending timeout flag; go to DONE.
- Otherwise counter increments.

DONE (exactly one cycle):
- stall = 0, so the pipeline advances past the instruction.
- Normal read: load_valid = 1.
- Timeout: err_timeout = 1, kill_wb = 1, load_valid = 0.
- Next state is IDLE. A new access is evaluated in IDLE on the following cycle. No overlap between transactions.

Latency:
- Ack in the k-th WAIT cycle (k >= 1) gives stall = 1 for k+1 cycles, then DONE.
- Worst case is TIMEOUT+1 stall cycles.

Other rules:
- stall_cycles increments every cycle stall = 1 and saturates at 2^CNT_W - 1.
- Outputs err_*, kill_wb and load_valid are 1 for at most one cycle per instruction.
- Non-memory instructions pass with zero added latency.

Test Plan:
- Aligned read at addr 0x0000_0010; ack on the 2nd WAIT cycle with rdata 0xDEAD_BEEF -> stall high for 3 cycles, dmem_we = 0, then load_valid = 1 and load_data = 0xDEAD_BEEF for 1 cycle; stall_cycles = 3.
- Write at addr 0x0000_0020, wdata 0x1234_5678; ack on the 1st WAIT cycle -> dmem_we = 1 with addr/wdata stable while req = 1, stall for 2 cycles, load_valid stays 0.
- Read at addr 0x0000_0013 -> err_align = 1 and kill_wb = 1 for 1 cycle, dmem_req never rises, stall = 0. mem_read = mem_write = 1 -> err_illegal = 1 and kill_wb = 1, no request.
- TIMEOUT = 4, read with ack never asserted -> req high for exactly 4 cycles, stall for 5 cycles, then err_timeout = 1, kill_wb = 1, load_data = 0.
- Reset asserted on the 2nd WAIT cycle, then ack pulsed the next cycle -> dmem_req = 0 and state IDLE after the reset edge, no load_valid, stall_cycles = 0.
- Back-to-back loads, each acked on the 1st WAIT cycle -> two separate req pulses separated by DONE and IDLE cycles, both load_data values delivered in order, stall_cycles = 4.
